fetch_unit: RTL and testbench

//  Instruction fetch stage that owns the fetch PC, issues in-order reads to

---
 rtl/proc_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants and the fetch FSM state type for the instruction-fetch slice.
package proc_pkg;
    localparam int          PC_W       = 10;
    localparam int          INSTR_W    = 16;
    localparam int          FIFO_DEPTH = 4;
    localparam int unsigned RESET_PC   = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head; flush empties it and beats a same-cycle push.
module fetch_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem reads under a credit limit,
// buffers {instr, pc} for decode and discards in-flight words after a redirect.
module fetch_unit #(
    parameter int          PC_W       = proc_pkg::PC_W,
    parameter int          INSTR_W    = proc_pkg::INSTR_W,
    parameter int          FIFO_DEPTH = proc_pkg::FIFO_DEPTH,
    parameter int unsigned RESET_PC   = proc_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_W-1:0]     instr,
    output logic [PC_W-1:0]        instr_pc,
    input  logic                   instr_ready,
    output proc_pkg::fetch_state_e state_o
);
    localparam int              CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int              QW     = INSTR_W + PC_W;
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    proc_pkg::fetch_state_e state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             started_q;

    logic             grant, rsp_keep, handshake, credit_ok;
    logic [CNT_W-1:0] q_count, tag_count;
    logic             q_full, q_empty, tag_full, tag_empty;
    logic [QW-1:0]    q_head;
    logic [PC_W-1:0]  tag_pc;
    logic             unused_tag_count;

    // Handshakes: a transfer happens on a rising edge where valid & ready (req & gnt) are both high;
    // valid never depends on ready, and imem_gnt is ignored while imem_req is low.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req  = started_q && (state_q == proc_pkg::RUN) && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign rsp_keep  = imem_rvalid && (discard_q == '0);
    assign handshake = instr_valid && instr_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        discard_d     = discard_q;

        if (grant) fetch_pc_d = fetch_pc_q + PC_W'(1);
        if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);

        // Everything still in flight after this cycle's updates belongs to the old path.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (state_q == proc_pkg::RUN) discard_d = outstanding_d;
        end

        state_d = (discard_d != '0) ? proc_pkg::FLUSH : proc_pkg::RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= proc_pkg::RUN;
            fetch_pc_q    <= RST_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            started_q     <= 1'b1;
        end
    end

    fetch_fifo #(.WIDTH(PC_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (grant && !tag_full),
        .wdata_i (fetch_pc_q),
        .pop_i   (rsp_keep && !tag_empty),
        .flush_i (redirect),
        .rdata_o (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (rsp_keep && !q_full),
        .wdata_i ({imem_rdata, tag_pc}),
        .pop_i   (handshake),
        .flush_i (redirect),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign unused_tag_count = ^tag_count;

    assign instr_valid = !q_empty;
    assign instr       = instr_valid ? q_head[QW-1:PC_W] : '0;
    assign instr_pc    = instr_valid ? q_head[PC_W-1:0]  : '0;
    assign state_o     = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based model of the fetch stream.
module tb_fetch_unit;
    import proc_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req, imem_gnt, imem_rvalid;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid, instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    fetch_state_e       state_o;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .state_o     (state_o)
    );

    typedef struct packed { logic stale; logic [PC_W-1:0] pc; } fl_t;
    typedef struct packed { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] word; } ex_t;
    typedef struct packed { int unsigned due; logic [INSTR_W-1:0] data; } rsp_t;

    fl_t  fl_q[$];
    ex_t  exp_q[$];
    rsp_t rq[$];
    logic [PC_W-1:0]    mdl_pc;
    logic               live;

    logic [PC_W-1:0]    hs_log[$];
    logic [INSTR_W-1:0] hs_word[$];
    int unsigned        hs_cyc[$];
    int unsigned        cyc, rel_cyc;
    int                 grants;

    int   gnt_pct, rdy_pct, lat, arm_inflight, arm_pc;
    bit   rand_redir, redir_pend;
    logic [PC_W-1:0] redir_tgt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {6'h2A, a};
    endfunction

    function automatic bit flushing();
        foreach (fl_q[i]) if (fl_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_exp();
        return live && !flushing() && !redirect && ((fl_q.size() + exp_q.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        fl_q.delete();
        exp_q.delete();
        rq.delete();
        mdl_pc = PC_W'(RESET_PC);
        live   = 1'b0;
    endtask

    // Reference behaviour at one clock edge, in the order the stage resolves events.
    task automatic model_edge();
        bit hs, g;
        fl_t f;
        hs = (exp_q.size() != 0) && instr_ready;
        g  = req_exp() && imem_gnt;
        if (hs) void'(exp_q.pop_front());
        if (imem_rvalid && fl_q.size() != 0) begin
            f = fl_q.pop_front();
            if (!f.stale) exp_q.push_back('{pc: f.pc, word: mem_word(f.pc)});
        end
        if (g) begin
            fl_q.push_back('{stale: 1'b0, pc: mdl_pc});
            mdl_pc = mdl_pc + 1'b1;
        end
        if (redirect) begin
            exp_q.delete();
            foreach (fl_q[i]) fl_q[i].stale = 1'b1;
            mdl_pc = redirect_pc;
        end
        live = 1'b1;
    endtask

    task automatic imem_edge();
        if (imem_rvalid && rq.size() != 0) void'(rq.pop_front());
        if (imem_req && imem_gnt) begin
            rq.push_back('{due: cyc + lat, data: mem_word(imem_addr)});
            grants++;
        end
    endtask

    task automatic drive();
        bit was_redir;
        was_redir   = redirect;
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        instr_ready = ($urandom_range(0, 99) < rdy_pct);
        if (reset && rq.size() != 0 && rq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rq[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = INSTR_W'($urandom);
        end
        redirect = 1'b0;
        if (!reset) begin
            redirect = 1'b0;
        end else if (redir_pend) begin
            redirect = 1'b1; redirect_pc = redir_tgt; redir_pend = 1'b0;
        end else if (arm_inflight >= 0 && fl_q.size() == arm_inflight && !flushing()) begin
            redirect = 1'b1; redirect_pc = redir_tgt; arm_inflight = -1;
        end else if (arm_pc >= 0 && exp_q.size() != 0 && exp_q[0].pc == PC_W'(arm_pc) && instr_ready) begin
            redirect = 1'b1; redirect_pc = redir_tgt; arm_pc = -1;
        end else if (rand_redir && !was_redir && $urandom_range(0, 24) == 0) begin
            redirect = 1'b1; redirect_pc = PC_W'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (instr_valid && instr_ready) begin
                hs_log.push_back(instr_pc);
                hs_word.push_back(instr);
                hs_cyc.push_back(cyc);
            end
            model_edge();
            imem_edge();
        end else begin
            rq.delete();
        end
        cyc++;
        #1;
        drive();
    endtask

    task automatic clear_log();
        hs_log.delete();
        hs_word.delete();
        hs_cyc.delete();
    endtask

    task automatic apply_reset();
        #2;
        reset       = 1'b0;
        model_clear();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        repeat (3) tick();
        reset   = 1'b1;
        grants  = 0;
        rel_cyc = cyc;
        clear_log();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) begin
                chk("r_req", imem_req, 0);
                chk("r_addr", imem_addr, RESET_PC);
                chk("r_valid", instr_valid, 0);
                chk("r_instr", instr, 0);
                chk("r_pc", instr_pc, 0);
                chk("r_state", state_o, RUN);
            end else begin
                chk("req", imem_req, req_exp());
                chk("addr", imem_addr, mdl_pc);
                chk("valid", instr_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("instr_pc", instr_pc, exp_q[0].pc);
                    chk("instr", instr, exp_q[0].word);
                end
                chk("state", state_o, flushing() ? FLUSH : RUN);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [INSTR_W-1:0] t1_words [4];
        int n5, n6, idx, drop;
        t1_words = '{16'hA800, 16'hA801, 16'hA802, 16'hA803};
        gnt_pct = 100; rdy_pct = 100; lat = 1;
        arm_inflight = -1; arm_pc = -1; rand_redir = 1'b0; redir_pend = 1'b0; redir_tgt = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0; cyc = 0; grants = 0;
        model_clear();
        chk_en = 1'b1;

        // 1: back-to-back stream after reset, latency 1
        apply_reset();
        repeat (12) tick();
        chk("t1_count", hs_log.size() >= 8, 1);
        for (int i = 0; i < 4; i++) begin
            if (hs_log.size() > i + 1) begin
                chk("t1_pc", hs_log[i], i);
                chk("t1_word", hs_word[i], t1_words[i]);
                chk("t1_back2back", hs_cyc[i+1], hs_cyc[i] + 1);
            end
        end
        if (hs_cyc.size() != 0) chk("t1_first_latency", hs_cyc[0], rel_cyc + 3);

        // 2: decode stalled -> exactly DEPTH requests, then drain in order
        apply_reset();
        rdy_pct = 0;
        repeat (12) tick();
        #1;
        chk("t2_grants", grants, DEPTH);
        chk("t2_req_low", imem_req, 0);
        rdy_pct = 100;
        clear_log();
        repeat (10) tick();
        chk("t2_resume", hs_log.size() >= 5, 1);
        for (int i = 0; i < 5; i++) if (hs_log.size() > i) chk("t2_pc", hs_log[i], i);

        // 3: redirect with two reads in flight, latency 3
        apply_reset();
        lat = 3; redir_tgt = 10'h200; arm_inflight = 2;
        for (int i = 0; i < 20 && arm_inflight >= 0; i++) tick();
        chk("t3_armed", arm_inflight, -1);
        tick();
        chk("t3_state_flush", state_o, FLUSH);
        drop = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_rvalid && state_o == FLUSH) drop++;
            tick();
        end
        chk("t3_dropped", drop, 2);
        chk("t3_first_pc", hs_log.size() != 0 ? hs_log[0] : 10'h3FF, 10'h200);
        if (hs_log.size() > 1) chk("t3_second_pc", hs_log[1], 10'h201);

        // 4: redirect in the same cycle as the handshake of PC 5
        apply_reset();
        lat = 1; redir_tgt = 10'h123; arm_pc = 5;
        for (int i = 0; i < 30 && arm_pc >= 0; i++) tick();
        chk("t4_armed", arm_pc, -1);
        repeat (12) tick();
        n5 = 0; n6 = 0; idx = -1;
        foreach (hs_log[i]) begin
            if (hs_log[i] == 10'd5) begin n5++; idx = i; end
            if (hs_log[i] == 10'd6) n6++;
        end
        chk("t4_pc5_once", n5, 1);
        chk("t4_pc6_never", n6, 0);
        if (idx >= 0 && hs_log.size() > idx + 1) chk("t4_next_pc", hs_log[idx+1], 10'h123);
        else chk("t4_next_present", 0, 1);

        // 5: sequential wrap at the top of the address space
        clear_log();
        redir_tgt = 10'h3FE; redir_pend = 1'b1;
        repeat (14) tick();
        idx = -1;
        foreach (hs_log[i]) if (idx < 0 && hs_log[i] == 10'h3FE) idx = i;
        if (idx >= 0 && hs_log.size() > idx + 2) begin
            chk("t5_3ff", hs_log[idx+1], 10'h3FF);
            chk("t5_wrap", hs_log[idx+2], 10'h000);
            chk("t5_wrap_word", hs_word[idx+2], 16'hA800);
        end else chk("t5_found", 0, 1);

        // 6: reset while flushing with a response on the bus
        apply_reset();
        lat = 3; redir_tgt = 10'h050; arm_inflight = 2;
        for (int i = 0; i < 20 && arm_inflight >= 0; i++) tick();
        tick();
        tick();
        chk("t6_pre_flush", state_o, FLUSH);
        chk("t6_pre_rvalid", imem_rvalid, 1);
        apply_reset();
        repeat (12) tick();
        chk("t6_restart", hs_log.size() >= 2, 1);
        if (hs_log.size() >= 2) begin
            chk("t6_pc0", hs_log[0], RESET_PC);
            chk("t6_pc1", hs_log[1], RESET_PC + 1);
        end

        // Random traffic with random redirects across several latency settings
        rand_redir = 1'b1;
        for (int ph = 0; ph < 6; ph++) begin
            lat     = $urandom_range(1, 4);
            gnt_pct = $urandom_range(30, 100);
            rdy_pct = $urandom_range(20, 100);
            repeat (300) tick();
        end
        rand_redir = 1'b0;
        repeat (20) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
